axi_rd_slave_mem: RTL and testbench

//  AXI4 read-channel slave responder, backed by a word-addressed memory array.

---
 rtl/axi_rd_pkg.sv | 36 +++
 rtl/axi_rd_addr_gen.sv | 31 +++
 rtl/axi_rd_slave_mem.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_rd_slave_mem.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types for the AXI4 read-channel slave memory: burst/response encodings and the AR request payload.
package axi_rd_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_e                burst;
    logic [3:0]            region;
  } ar_req_t;

  // Wrapping bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts; arithmetic wraps modulo 2^ADDR_W.
module axi_rd_addr_gen
  import axi_rd_pkg::*;
#(
  parameter int unsigned ADDR_W = AXI_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [7:0]        i_len,
  input  burst_e            i_burst,
  output logic [ADDR_W-1:0] o_next_addr_c
);

  logic [ADDR_W-1:0] w_bytes;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_wrap_mask;

  always_comb begin
    w_bytes       = ADDR_W'(1) << i_size;
    w_incr        = i_addr + w_bytes;
    // Wrap container is (len+1)*bytes, a power of two for legal lengths.
    w_wrap_mask   = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
    o_next_addr_c = w_incr;
    case (i_burst)
      FIXED:   o_next_addr_c = i_addr;
      WRAP:    o_next_addr_c = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default: o_next_addr_c = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_rd_slave_mem.sv
// AXI4 read slave: AR request queue, burst FSM, word-addressed memory with backdoor
// write port, and registered R channel.
module axi_rd_slave_mem
  import axi_rd_pkg::*;
#(
  parameter int unsigned ID_W      = AXI_ID_W,
  parameter int unsigned ADDR_W    = AXI_ADDR_W,
  parameter int unsigned DATA_W    = AXI_DATA_W,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AR_QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ID_W-1:0]          ARID,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic [7:0]               ARLEN,
  input  logic [2:0]               ARSIZE,
  input  logic [1:0]               ARBURST,
  input  logic [3:0]               ARREGION,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [ID_W-1:0]          RID,
  output logic [DATA_W-1:0]        RDATA,
  output logic [1:0]               RRESP,
  output logic                     RLAST,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]        mem_wdata
);

  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned QP_W   = $clog2(AR_QDEPTH);
  localparam int unsigned QC_W   = QP_W + 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  ar_req_t           r_q [AR_QDEPTH];
  logic [QP_W-1:0]   r_wptr, r_rptr;
  logic [QC_W-1:0]   r_count, w_count_nxt;
  logic              r_arready;
  logic              w_push, w_pop, w_load, w_clear, w_q_empty;
  ar_req_t           w_push_req, w_head;

  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_beat;
  logic [2:0]        r_size;
  burst_e            r_burst;
  resp_e             r_bresp;
  logic              r_berr;

  logic              r_rvalid, r_rlast;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  resp_e             r_rresp;

  logic [ADDR_W-1:0] w_next_addr, w_ld_addr, w_ld_word;
  logic [ID_W-1:0]   w_ld_id;
  logic [7:0]        w_ld_beat, w_ld_len;
  resp_e             w_ld_bresp;
  logic              w_ld_berr, w_ld_inrange, w_h_dec, w_h_slv;

  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RLAST   = r_rlast;
  assign RID     = r_rid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

  // AR queue; ready looks at post-update occupancy so a full queue never passes through.
  always_comb begin
    w_push_req.id     = AXI_ID_W'(ARID);
    w_push_req.addr   = AXI_ADDR_W'(ARADDR);
    w_push_req.len    = ARLEN;
    w_push_req.size   = ARSIZE;
    w_push_req.burst  = burst_e'(ARBURST);
    w_push_req.region = ARREGION;
  end

  assign w_push      = ARVALID && r_arready;
  assign w_head      = r_q[r_rptr];
  assign w_q_empty   = (r_count == '0);
  assign w_count_nxt = r_count + QC_W'(w_push) - QC_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= w_push_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_arready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + QP_W'(1);
      if (w_pop)  r_rptr <= r_rptr + QP_W'(1);
      r_count   <= w_count_nxt;
      r_arready <= (w_count_nxt != QC_W'(AR_QDEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_q_empty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (r_rvalid && RREADY) begin
          if (!r_rlast) begin
            w_load = 1'b1;
          end else if (!w_q_empty) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  axi_rd_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_addr        (r_addr),
    .i_size        (r_size),
    .i_len         (r_len),
    .i_burst       (r_burst),
    .o_next_addr_c (w_next_addr)
  );

  // Source of the beat being loaded: a freshly popped request or the next beat of the current one.
  always_comb begin
    w_h_dec    = (w_head.region != 4'd0);
    w_h_slv    = (w_head.size > 3'(OFF_W)) || (w_head.burst == RSVD) ||
                 ((w_head.burst == WRAP) && !wrap_len_ok(w_head.len));
    w_ld_id    = r_id;
    w_ld_addr  = w_next_addr;
    w_ld_beat  = r_beat + 8'd1;
    w_ld_len   = r_len;
    w_ld_bresp = r_bresp;
    w_ld_berr  = r_berr;
    if (w_pop) begin
      w_ld_id   = ID_W'(w_head.id);
      w_ld_addr = ADDR_W'(w_head.addr);
      w_ld_beat = 8'd0;
      w_ld_len  = w_head.len;
      w_ld_berr = w_h_dec || w_h_slv;
      if (w_h_dec)      w_ld_bresp = DECERR;
      else if (w_h_slv) w_ld_bresp = SLVERR;
      else              w_ld_bresp = OKAY;
    end
  end

  assign w_ld_word    = w_ld_addr >> OFF_W;
  assign w_ld_inrange = (w_ld_word < ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (mem_we) r_mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= FIXED;
      r_bresp <= OKAY;
      r_berr  <= 1'b0;
    end else if (w_load) begin
      r_addr <= w_ld_addr;
      r_beat <= w_ld_beat;
      if (w_pop) begin
        r_id    <= w_ld_id;
        r_len   <= w_head.len;
        r_size  <= w_head.size;
        r_burst <= w_head.burst;
        r_bresp <= w_ld_bresp;
        r_berr  <= w_ld_berr;
      end
    end
  end

  // R output registers; a read racing a backdoor write sees the pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
    end else if (w_load) begin
      r_rvalid <= 1'b1;
      r_rid    <= w_ld_id;
      r_rlast  <= (w_ld_beat == w_ld_len);
      if (w_ld_berr) begin
        r_rresp <= w_ld_bresp;
        r_rdata <= '0;
      end else if (!w_ld_inrange) begin
        r_rresp <= SLVERR;
        r_rdata <= '0;
      end else begin
        r_rresp <= OKAY;
        r_rdata <= r_mem[w_ld_word[MEM_AW-1:0]];
      end
    end else if (w_clear) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rd_slave_mem.sv
// Directed bench for axi_rd_slave_mem (ID_W=4, ADDR_W=32, DATA_W=32, DEPTH=1024, AR_QDEPTH=2).
module tb_axi_rd_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [3:0]  ARREGION = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_waddr = '0;
  logic [31:0] mem_wdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cap_data [16];
  logic [1:0]  cap_resp [16];
  logic        cap_last [16];
  logic [3:0]  cap_id   [16];
  int          cap_wait [16];
  int          cap_n;

  axi_rd_slave_mem dut (
    .clk(clk), .rst_n(rst_n),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mw(input int i);
    return {16'hA5A5, 16'(i)};
  endfunction

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] region);
    int w;
    @(negedge clk);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARREGION = region;
    ARVALID = 1'b1;
    w = 0;
    while (!ARREADY && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (ARREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_handshake id=%0d: ARREADY=%b after %0d cycles, required 1", id, ARREADY, w);
    end
    @(negedge clk);
    ARVALID = 1'b0;
  endtask

  // Records up to n beats starting at a falling edge; assumes RREADY is held high.
  task automatic collect(input int n);
    cap_n = 0;
    for (int b = 0; b < n; b++) begin
      int w;
      w = 0;
      while (!RVALID && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!RVALID) break;
      cap_data[b] = RDATA; cap_resp[b] = RRESP; cap_last[b] = RLAST;
      cap_id[b] = RID; cap_wait[b] = w;
      cap_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL reset_arready: got %b, required 0", ARREADY); end
    n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b, required 0", RVALID); end
    n_tests++; if (RLAST !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b, required 0", RLAST); end
    n_tests++; if (RID !== 4'd0) begin n_fail++; $display("FAIL reset_rid: got %0d, required 0", RID); end
    n_tests++; if (RDATA !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", RDATA); end
    n_tests++; if (RRESP !== 2'd0) begin n_fail++; $display("FAIL reset_rresp: got %0d, required 0", RRESP); end
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      mem_we = 1'b1; mem_waddr = 10'(i); mem_wdata = mw(i);
    end
    @(negedge clk);
    mem_we = 1'b0;
    rst_n = 1'b1;
    n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL release_arready_pre: got %b, required 0", ARREADY); end
    @(negedge clk);
    n_tests++; if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL release_arready: got %b, required 1", ARREADY); end
  endtask

  task automatic test_incr;
    RREADY = 1'b1;
    ar_send(4'd5, 32'h10, 8'd3, 3'd2, 2'd1, 4'd0);
    n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL incr_early_rvalid: got %b, required 0", RVALID); end
    collect(4);
    n_tests++; if (cap_n !== 4) begin n_fail++; $display("FAIL incr_beats: got %0d, required 4", cap_n); end
    n_tests++; if (cap_wait[0] !== 1) begin n_fail++; $display("FAIL incr_latency: waited %0d, required 1", cap_wait[0]); end
    for (int b = 0; b < cap_n; b++) begin
      n_tests++; if (cap_data[b] !== mw(4 + b)) begin n_fail++; $display("FAIL incr_data[%0d]: got %h, required %h", b, cap_data[b], mw(4 + b)); end
      n_tests++; if (cap_id[b] !== 4'd5) begin n_fail++; $display("FAIL incr_rid[%0d]: got %0d, required 5", b, cap_id[b]); end
      n_tests++; if (cap_resp[b] !== 2'd0) begin n_fail++; $display("FAIL incr_resp[%0d]: got %0d, required 0", b, cap_resp[b]); end
      n_tests++; if (cap_last[b] !== (b == 3)) begin n_fail++; $display("FAIL incr_last[%0d]: got %b, required %b", b, cap_last[b], (b == 3)); end
      if (b > 0) begin
        n_tests++; if (cap_wait[b] !== 0) begin n_fail++; $display("FAIL incr_gap[%0d]: waited %0d, required 0", b, cap_wait[b]); end
      end
    end
    n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL incr_idle: RVALID=%b, required 0", RVALID); end
  endtask

  task automatic test_wrap;
    int order [4];
    order = '{3, 0, 1, 2};
    RREADY = 1'b1;
    ar_send(4'd6, 32'h0C, 8'd3, 3'd2, 2'd2, 4'd0);
    collect(4);
    n_tests++; if (cap_n !== 4) begin n_fail++; $display("FAIL wrap_beats: got %0d, required 4", cap_n); end
    for (int b = 0; b < cap_n; b++) begin
      n_tests++; if (cap_data[b] !== mw(order[b])) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h, required %h", b, cap_data[b], mw(order[b])); end
      n_tests++; if (cap_resp[b] !== 2'd0) begin n_fail++; $display("FAIL wrap_resp[%0d]: got %0d, required 0", b, cap_resp[b]); end
    end
    n_tests++; if (cap_last[3] !== 1'b1) begin n_fail++; $display("FAIL wrap_last: got %b, required 1", cap_last[3]); end
  endtask

  task automatic test_back_to_back;
    RREADY = 1'b0;
    ar_send(4'd1, 32'd40, 8'd0, 3'd2, 2'd1, 4'd0);
    ar_send(4'd2, 32'd44, 8'd0, 3'd2, 2'd1, 4'd0);
    ar_send(4'd3, 32'd48, 8'd0, 3'd2, 2'd1, 4'd0);
    n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL q_full_arready: got %b, required 0", ARREADY); end
    ARID = 4'd4; ARADDR = 32'h100; ARLEN = 8'd0; ARVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if (ARREADY !== 1'b0) begin n_fail++; $display("FAIL q_full_hold[%0d]: ARREADY=%b, required 0", k, ARREADY); end
      n_tests++; if (RVALID !== 1'b1 || RID !== 4'd1 || RDATA !== mw(10) || RLAST !== 1'b1)
        begin n_fail++; $display("FAIL r_stable[%0d]: got v=%b id=%0d d=%h l=%b, required v=1 id=1 d=%h l=1", k, RVALID, RID, RDATA, RLAST, mw(10)); end
    end
    ARVALID = 1'b0;
    RREADY = 1'b1;
    collect(3);
    n_tests++; if (cap_n !== 3) begin n_fail++; $display("FAIL b2b_beats: got %0d, required 3", cap_n); end
    for (int b = 0; b < cap_n; b++) begin
      n_tests++; if (cap_id[b] !== 4'(b + 1)) begin n_fail++; $display("FAIL b2b_id[%0d]: got %0d, required %0d", b, cap_id[b], b + 1); end
      n_tests++; if (cap_data[b] !== mw(10 + b)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h, required %h", b, cap_data[b], mw(10 + b)); end
      n_tests++; if (cap_wait[b] !== 0) begin n_fail++; $display("FAIL b2b_gap[%0d]: waited %0d, required 0", b, cap_wait[b]); end
      n_tests++; if (cap_last[b] !== 1'b1) begin n_fail++; $display("FAIL b2b_last[%0d]: got %b, required 1", b, cap_last[b]); end
    end
    n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: RVALID=%b, required 0", RVALID); end
    n_tests++; if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_arready: got %b, required 1", ARREADY); end
  endtask

  task automatic test_errors;
    logic [1:0]  exp_resp [4];
    logic [31:0] exp_data [4];
    RREADY = 1'b1;
    ar_send(4'd7, 32'h20, 8'd1, 3'd2, 2'd1, 4'd1);
    collect(2);
    n_tests++; if (cap_n !== 2) begin n_fail++; $display("FAIL dec_beats: got %0d, required 2", cap_n); end
    for (int b = 0; b < cap_n; b++) begin
      n_tests++; if (cap_resp[b] !== 2'd3 || cap_data[b] !== 32'd0)
        begin n_fail++; $display("FAIL dec_beat[%0d]: got resp=%0d data=%h, required resp=3 data=0", b, cap_resp[b], cap_data[b]); end
    end
    n_tests++; if (cap_last[1] !== 1'b1) begin n_fail++; $display("FAIL dec_last: got %b, required 1", cap_last[1]); end

    exp_resp = '{2'd0, 2'd0, 2'd2, 2'd2};
    exp_data = '{mw(1022), mw(1023), 32'd0, 32'd0};
    ar_send(4'd8, 32'hFF8, 8'd3, 3'd2, 2'd1, 4'd0);
    collect(4);
    n_tests++; if (cap_n !== 4) begin n_fail++; $display("FAIL depth_beats: got %0d, required 4", cap_n); end
    for (int b = 0; b < cap_n; b++) begin
      n_tests++; if (cap_resp[b] !== exp_resp[b] || cap_data[b] !== exp_data[b])
        begin n_fail++; $display("FAIL depth_beat[%0d]: got resp=%0d data=%h, required resp=%0d data=%h", b, cap_resp[b], cap_data[b], exp_resp[b], exp_data[b]); end
    end
    n_tests++; if (cap_last[3] !== 1'b1) begin n_fail++; $display("FAIL depth_last: got %b, required 1", cap_last[3]); end

    ar_send(4'd9, 32'h0, 8'd0, 3'd3, 2'd1, 4'd0);
    collect(1);
    n_tests++; if (cap_n !== 1 || cap_resp[0] !== 2'd2 || cap_data[0] !== 32'd0)
      begin n_fail++; $display("FAIL size_err: got n=%0d resp=%0d data=%h, required n=1 resp=2 data=0", cap_n, cap_resp[0], cap_data[0]); end

    ar_send(4'd10, 32'h0, 8'd2, 3'd2, 2'd2, 4'd0);
    collect(3);
    n_tests++; if (cap_n !== 3) begin n_fail++; $display("FAIL wraplen_beats: got %0d, required 3", cap_n); end
    for (int b = 0; b < cap_n; b++) begin
      n_tests++; if (cap_resp[b] !== 2'd2 || cap_data[b] !== 32'd0 || cap_last[b] !== (b == 2))
        begin n_fail++; $display("FAIL wraplen_beat[%0d]: got resp=%0d data=%h last=%b, required resp=2 data=0 last=%b", b, cap_resp[b], cap_data[b], cap_last[b], (b == 2)); end
    end

    ar_send(4'd11, 32'h4, 8'd0, 3'd2, 2'd3, 4'd0);
    collect(1);
    n_tests++; if (cap_n !== 1 || cap_resp[0] !== 2'd2 || cap_data[0] !== 32'd0)
      begin n_fail++; $display("FAIL rsvd_burst: got n=%0d resp=%0d data=%h, required n=1 resp=2 data=0", cap_n, cap_resp[0], cap_data[0]); end
  endtask

  task automatic test_collision;
    RREADY = 1'b1;
    ar_send(4'd12, 32'h40, 8'd2, 3'd2, 2'd0, 4'd0);
    @(negedge clk);
    n_tests++; if (RVALID !== 1'b1 || RDATA !== mw(16)) begin n_fail++; $display("FAIL fixed_beat0: got v=%b d=%h, required v=1 d=%h", RVALID, RDATA, mw(16)); end
    mem_we = 1'b1; mem_waddr = 10'd16; mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_we = 1'b0;
    n_tests++; if (RDATA !== mw(16) || RLAST !== 1'b0) begin n_fail++; $display("FAIL collide_old: got d=%h l=%b, required d=%h l=0", RDATA, RLAST, mw(16)); end
    @(negedge clk);
    n_tests++; if (RDATA !== 32'hDEAD_BEEF || RLAST !== 1'b1) begin n_fail++; $display("FAIL collide_new: got d=%h l=%b, required d=deadbeef l=1", RDATA, RLAST); end
    @(negedge clk);
    n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL fixed_idle: RVALID=%b, required 0", RVALID); end
  endtask

  task automatic test_reset_mid;
    RREADY = 1'b1;
    ar_send(4'd13, 32'h80, 8'd3, 3'd2, 2'd1, 4'd0);
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (RVALID !== 1'b1 || RDATA !== mw(33)) begin n_fail++; $display("FAIL mid_beat1: got v=%b d=%h, required v=1 d=%h", RVALID, RDATA, mw(33)); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (RVALID !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'd0 || RID !== 4'd0 || ARREADY !== 1'b0)
      begin n_fail++; $display("FAIL mid_async: got v=%b l=%b d=%h id=%0d ar=%b, required all 0", RVALID, RLAST, RDATA, RID, ARREADY); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (ARREADY !== 1'b1) begin n_fail++; $display("FAIL mid_arready: got %b, required 1", ARREADY); end
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL mid_residual[%0d]: RVALID=%b, required 0", k, RVALID); end
      @(negedge clk);
    end
    ar_send(4'd14, 32'h14, 8'd0, 3'd2, 2'd1, 4'd0);
    collect(1);
    n_tests++; if (cap_n !== 1 || cap_data[0] !== mw(5) || cap_id[0] !== 4'd14)
      begin n_fail++; $display("FAIL mid_mem_kept: got n=%0d d=%h id=%0d, required n=1 d=%h id=14", cap_n, cap_data[0], cap_id[0], mw(5)); end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_back_to_back();
    test_errors();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
